trng_health_packer: RTL and testbench
=====================================

// Module: trng_health_packer
// PURPOSE
//  Downstream of the TRNG sampler's Von Neumann debiaser: consumes debiased bits (bit_in/bit_valid),
//  runs SP 800-90B continuous health tests (repetition count RCT, adaptive proportion APT), and packs
//  healthy bits MSB-first into words. Words go to the register/AXI side over a valid/ready handshake.
//  Any health failure latches a sticky alarm that blocks output until software clears it.
// PARAMETERS
//  WORD_W       32    output word width; bits per packed word
//  RCT_CUTOFF   32    run length of identical bits that fails RCT (>=2)
//  APT_WINDOW   512   APT window length in accepted bits (power of 2)
//  APT_CUTOFF   410   matches of window's first bit, first bit included, that fail APT
//  STARTUP_BITS 1024  bits tested but never emitted after enable/clear
// PORTS
//  clk          in   1       system clock
//  rst          in   1       async active-high reset
//  enable       in   1       accept bits; 0 = idle, all state held
//  clear        in   1       sync clear: tests, packer, alarm, overflow -> reset values
//  bit_in       in   1       debiased random bit
//  bit_valid    in   1       1-cycle strobe, bit_in valid
//  word_out     out  WORD_W  packed random word
//  word_valid   out  1       word_out valid
//  word_ready   in   1       consumer accepts word_out
//  rct_fail     out  1       1-cycle pulse on RCT failure
//  apt_fail     out  1       1-cycle pulse on APT failure
//  alarm        out  1       sticky health alarm
//  overflow     out  1       sticky: completed word dropped, output register full
//  startup_done out  1       1 once STARTUP_BITS accepted without failure
// BEHAVIOUR
//  - Reset: all outputs, counters, shift reg, state = 0; state STARTUP.
//  - Accepted bit: bit_valid & enable & state!=ALARM & !clear. clear beats everything same cycle.
//  - States: STARTUP -> RUN after STARTUP_BITS accepted bits; STARTUP|RUN -> ALARM on any test fail;
//    ALARM -> STARTUP only on clear. enable=0 freezes state and counters.
//  - RCT: run_len=1 on first bit or bit!=last; else run_len+1 (saturating). run_len==RCT_CUTOFF -> fail.
//  - APT: win_idx 0..APT_WINDOW-1 wraps; idx 0 latches ref bit, match_cnt=1; later matches +1.
//    match_cnt==APT_CUTOFF -> fail. New window restarts count; no carry across windows.
//  - Fail on accepted bit at cycle N: rct_fail/apt_fail pulse, alarm=1 at N+1; failing bit not packed;
//    partial word discarded; word_valid forced 0 at N+1 (pending unread word discarded too).
//  - Both tests failing on same bit: both pulses in same cycle.
//  - Packer (RUN only): sr <= {sr[WORD_W-2:0],bit_in}; bit_cnt wraps 0..WORD_W-1; bits in STARTUP
//    are not packed, bit_cnt starts at 0 in RUN.
//  - Word completes (WORD_W-th bit) at cycle N: word_out/word_valid=1 at N+1 if output reg empty or
//    being accepted same cycle (word_valid&word_ready) -> new word loaded, valid stays 1.
//    If full and not accepted: new word dropped, overflow=1 (sticky), word_out unchanged.
//  - Handshake: transfer on word_valid&word_ready; word_out stable while word_valid; valid never
//    drops without transfer except on alarm/clear/rst.
//  - Mid-operation rst or clear: immediate return to reset values; no partial word survives.
// CONFIGURATION
//  TRNG_HEALTH_STATS_EN defined: adds outputs rct_fail_cnt[15:0], apt_fail_cnt[15:0], words_cnt[31:0];
//    fail counters +1 per fail pulse (saturate 16'hFFFF), words_cnt +1 per handshake (wraps);
//    all zeroed by rst only, NOT by clear.
//  Undefined: ports and counters absent; other behaviour identical.
// TESTING
//  Bench params: WORD_W=8, RCT_CUTOFF=4, APT_WINDOW=16, APT_CUTOFF=12, STARTUP_BITS=8.
//  1. Alternating 1,0 x8 then bits 1010_0110, word_ready=1 -> startup_done=1, word_out=8'hA6, 1-cycle valid.
//  2. After startup, bits 1,1,1,1 -> rct_fail & alarm at cycle after 4th bit; no word; further bits ignored.
//  3. 16-bit window, ref=0, 12 zeros interleaved non-runs (0,0,1,0,0,1,...) -> apt_fail on 12th zero match.
//  4. word_ready=0, two full words streamed -> first held as 8'h..., second dropped, overflow=1;
//     ready=1 -> first word transfers, valid drops.
//  5. Completion same cycle as handshake -> word_valid stays 1, word_out updates to new word.
//  6. Alarm, then clear pulse with bit_valid high -> bit dropped, alarm=0, state STARTUP; STATS_EN:
//     rct_fail_cnt retains 1 across clear, zero after rst.

Source files
------------

// File: rtl/trng_health_packer.sv
// ---------------------------------------------------------------------------
// trng_health_packer
//
// Takes debiased TRNG bits, runs the continuous repetition-count (RCT) and
// adaptive-proportion (APT) health tests on every accepted bit, and packs
// healthy bits MSB-first into WORD_W-bit words. Words leave through a single
// output register with a valid/ready handshake. Any test failure latches a
// sticky alarm that blocks all output until a synchronous clear.
//
// The first STARTUP_BITS accepted bits after reset/clear are tested but never
// packed. Packing begins with an empty word once the block reaches RUN.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   enable          0 = idle, tests/packer/FSM hold their state
//   clear           synchronous clear of tests, packer, alarm and overflow
//   bit_in          debiased random bit
//   bit_valid       one-cycle strobe qualifying bit_in
//   word_out        packed word, stable while word_valid is high
//   word_valid      word_out holds a word not yet taken
//   word_ready      consumer takes word_out when word_valid is high
//   rct_fail        one-cycle pulse on repetition-count failure
//   apt_fail        one-cycle pulse on adaptive-proportion failure
//   alarm           sticky health alarm
//   overflow        sticky, a completed word was dropped (output reg full)
//   startup_done    STARTUP_BITS bits accepted without failure
//
// Optional build macro TRNG_HEALTH_STATS_EN adds event counters
//   rct_fail_cnt[15:0], apt_fail_cnt[15:0] (saturating) and words_cnt[31:0]
//   (wrapping). They are zeroed only by rst, never by clear.
// ---------------------------------------------------------------------------
module trng_health_packer #(
    parameter int WORD_W       = 32,
    parameter int RCT_CUTOFF   = 32,
    parameter int APT_WINDOW   = 512,
    parameter int APT_CUTOFF   = 410,
    parameter int STARTUP_BITS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              clear,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              rct_fail,
    output logic              apt_fail,
    output logic              alarm,
    output logic              overflow,
    output logic              startup_done
`ifdef TRNG_HEALTH_STATS_EN
    ,
    output logic [15:0]       rct_fail_cnt,
    output logic [15:0]       apt_fail_cnt,
    output logic [31:0]       words_cnt
`endif
);

    localparam int RL_W = $clog2(RCT_CUTOFF + 1);
    localparam int WI_W = $clog2(APT_WINDOW);
    localparam int MC_W = $clog2(APT_WINDOW + 1);
    localparam int SU_W = $clog2(STARTUP_BITS + 1);
    localparam int BC_W = $clog2(WORD_W);

    localparam logic [RL_W-1:0] RL_ZERO   = {RL_W{1'b0}};
    localparam logic [RL_W-1:0] RL_ONE    = RL_W'(1);
    localparam logic [RL_W-1:0] RL_MAX    = {RL_W{1'b1}};
    localparam logic [RL_W-1:0] RCT_CUT_V = RL_W'(RCT_CUTOFF);
    localparam logic [WI_W-1:0] WI_ZERO   = {WI_W{1'b0}};
    localparam logic [WI_W-1:0] WI_ONE    = WI_W'(1);
    localparam logic [MC_W-1:0] MC_ZERO   = {MC_W{1'b0}};
    localparam logic [MC_W-1:0] MC_ONE    = MC_W'(1);
    localparam logic [MC_W-1:0] APT_CUT_V = MC_W'(APT_CUTOFF);
    localparam logic [SU_W-1:0] SU_ZERO   = {SU_W{1'b0}};
    localparam logic [SU_W-1:0] SU_ONE    = SU_W'(1);
    localparam logic [SU_W-1:0] SU_LAST_V = SU_W'(STARTUP_BITS - 1);
    localparam logic [BC_W-1:0] BC_ZERO   = {BC_W{1'b0}};
    localparam logic [BC_W-1:0] BC_ONE    = BC_W'(1);
    localparam logic [BC_W-1:0] BC_LAST_V = BC_W'(WORD_W - 1);

    typedef enum logic [1:0] {
        ST_STARTUP = 2'd0,
        ST_RUN     = 2'd1,
        ST_ALARM   = 2'd2
    } state_t;

    // Run-length increment that sticks at all-ones instead of wrapping.
    function automatic logic [RL_W-1:0] sat_inc(input logic [RL_W-1:0] v);
        if (v == RL_MAX) begin
            sat_inc = v;
        end else begin
            sat_inc = v + RL_ONE;
        end
    endfunction

    state_t              state_r;
    state_t              state_nxt_s;

    logic                last_bit_r;
    logic [RL_W-1:0]     run_len_r;      // 0 means no bit seen since reset/clear
    logic [WI_W-1:0]     win_idx_r;
    logic                ref_bit_r;
    logic [MC_W-1:0]     match_cnt_r;
    logic [SU_W-1:0]     startup_cnt_r;
    logic [WORD_W-2:0]   sr_r;           // only WORD_W-1 bits need to be held
    logic [BC_W-1:0]     bit_cnt_r;
    logic [WORD_W-1:0]   word_out_r;
    logic                word_valid_r;
    logic                rct_fail_r;
    logic                apt_fail_r;
    logic                alarm_r;
    logic                overflow_r;
    logic                startup_done_r;

    logic                accept_s;
    logic [RL_W-1:0]     run_len_nxt_s;
    logic [MC_W-1:0]     match_nxt_s;
    logic                rct_hit_s;
    logic                apt_hit_s;
    logic                fail_s;
    logic                startup_last_s;
    logic                pack_s;
    logic                word_done_s;
    logic                xfer_s;
    logic [WORD_W-1:0]   new_word_s;

    // Health-test next values and accept/complete/transfer qualifiers.
    always_comb begin
        accept_s       = bit_valid & enable & (state_r != ST_ALARM) & ~clear;
        xfer_s         = word_valid_r & word_ready;
        new_word_s     = {sr_r, bit_in};
        startup_last_s = (startup_cnt_r == SU_LAST_V);

        if ((run_len_r == RL_ZERO) || (bit_in != last_bit_r)) begin
            run_len_nxt_s = RL_ONE;
        end else begin
            run_len_nxt_s = sat_inc(run_len_r);
        end

        // Index 0 opens a new window; its own bit is the first match.
        if (win_idx_r == WI_ZERO) begin
            match_nxt_s = MC_ONE;
        end else if (bit_in == ref_bit_r) begin
            match_nxt_s = match_cnt_r + MC_ONE;
        end else begin
            match_nxt_s = match_cnt_r;
        end

        rct_hit_s   = accept_s & (run_len_nxt_s == RCT_CUT_V);
        apt_hit_s   = accept_s & (match_nxt_s == APT_CUT_V);
        fail_s      = rct_hit_s | apt_hit_s;
        pack_s      = accept_s & ~fail_s & (state_r == ST_RUN);
        word_done_s = pack_s & (bit_cnt_r == BC_LAST_V);
    end

    // FSM next state: clear dominates, any failure wins over progression.
    always_comb begin
        state_nxt_s = state_r;
        if (clear) begin
            state_nxt_s = ST_STARTUP;
        end else begin
            case (state_r)
                ST_STARTUP: begin
                    if (fail_s) begin
                        state_nxt_s = ST_ALARM;
                    end else if (accept_s && startup_last_s) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_STARTUP;
                    end
                end
                ST_RUN: begin
                    if (fail_s) begin
                        state_nxt_s = ST_ALARM;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_ALARM: begin
                    state_nxt_s = ST_ALARM;
                end
                default: begin
                    state_nxt_s = ST_STARTUP;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_STARTUP;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Health-test state, packer and output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_bit_r     <= 1'b0;
            run_len_r      <= RL_ZERO;
            win_idx_r      <= WI_ZERO;
            ref_bit_r      <= 1'b0;
            match_cnt_r    <= MC_ZERO;
            startup_cnt_r  <= SU_ZERO;
            sr_r           <= {(WORD_W-1){1'b0}};
            bit_cnt_r      <= BC_ZERO;
            word_out_r     <= {WORD_W{1'b0}};
            word_valid_r   <= 1'b0;
            rct_fail_r     <= 1'b0;
            apt_fail_r     <= 1'b0;
            alarm_r        <= 1'b0;
            overflow_r     <= 1'b0;
            startup_done_r <= 1'b0;
        end else if (clear) begin
            last_bit_r     <= 1'b0;
            run_len_r      <= RL_ZERO;
            win_idx_r      <= WI_ZERO;
            ref_bit_r      <= 1'b0;
            match_cnt_r    <= MC_ZERO;
            startup_cnt_r  <= SU_ZERO;
            sr_r           <= {(WORD_W-1){1'b0}};
            bit_cnt_r      <= BC_ZERO;
            word_out_r     <= {WORD_W{1'b0}};
            word_valid_r   <= 1'b0;
            rct_fail_r     <= 1'b0;
            apt_fail_r     <= 1'b0;
            alarm_r        <= 1'b0;
            overflow_r     <= 1'b0;
            startup_done_r <= 1'b0;
        end else begin
            rct_fail_r <= rct_hit_s;
            apt_fail_r <= apt_hit_s;

            if (accept_s) begin
                last_bit_r  <= bit_in;
                run_len_r   <= run_len_nxt_s;
                win_idx_r   <= win_idx_r + WI_ONE;   // power-of-2 window wraps
                match_cnt_r <= match_nxt_s;
                if (win_idx_r == WI_ZERO) begin
                    ref_bit_r <= bit_in;
                end
                if (state_r == ST_STARTUP) begin
                    startup_cnt_r <= startup_cnt_r + SU_ONE;
                end
            end

            if (fail_s) begin
                // Failing bit, partial word and any unread word are all discarded.
                alarm_r      <= 1'b1;
                sr_r         <= {(WORD_W-1){1'b0}};
                bit_cnt_r    <= BC_ZERO;
                word_valid_r <= 1'b0;
            end else begin
                if (pack_s) begin
                    sr_r <= new_word_s[WORD_W-2:0];
                    if (bit_cnt_r == BC_LAST_V) begin
                        bit_cnt_r <= BC_ZERO;
                    end else begin
                        bit_cnt_r <= bit_cnt_r + BC_ONE;
                    end
                end

                if (word_done_s) begin
                    if (!word_valid_r || word_ready) begin
                        word_out_r   <= new_word_s;
                        word_valid_r <= 1'b1;
                    end else begin
                        overflow_r <= 1'b1;
                    end
                end else if (xfer_s) begin
                    word_valid_r <= 1'b0;
                end

                if (accept_s && (state_r == ST_STARTUP) && startup_last_s) begin
                    startup_done_r <= 1'b1;
                end
            end
        end
    end

    assign word_out     = word_out_r;
    assign word_valid   = word_valid_r;
    assign rct_fail     = rct_fail_r;
    assign apt_fail     = apt_fail_r;
    assign alarm        = alarm_r;
    assign overflow     = overflow_r;
    assign startup_done = startup_done_r;

`ifdef TRNG_HEALTH_STATS_EN
    logic [15:0] rct_fail_cnt_r;
    logic [15:0] apt_fail_cnt_r;
    logic [31:0] words_cnt_r;

    // Event counters: they count across clear and are zeroed only by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rct_fail_cnt_r <= 16'h0000;
            apt_fail_cnt_r <= 16'h0000;
            words_cnt_r    <= 32'h0000_0000;
        end else begin
            if (rct_hit_s && (rct_fail_cnt_r != 16'hFFFF)) begin
                rct_fail_cnt_r <= rct_fail_cnt_r + 16'd1;
            end
            if (apt_hit_s && (apt_fail_cnt_r != 16'hFFFF)) begin
                apt_fail_cnt_r <= apt_fail_cnt_r + 16'd1;
            end
            if (xfer_s) begin
                words_cnt_r <= words_cnt_r + 32'd1;
            end
        end
    end

    assign rct_fail_cnt = rct_fail_cnt_r;
    assign apt_fail_cnt = apt_fail_cnt_r;
    assign words_cnt    = words_cnt_r;
`endif

endmodule

// File: tb/tb_trng_health_packer.sv
// ---------------------------------------------------------------------------
// tb_trng_health_packer
//
// Directed scenarios followed by a randomized phase. A behavioural model keeps
// the full history of accepted bits and derives run length, window matches
// and packed words from that history directly. Expected words go into a
// scoreboard queue; a separate monitor pops and compares on every handshake.
// ---------------------------------------------------------------------------
module tb_trng_health_packer;

    localparam int WORD_W       = 8;
    localparam int RCT_CUTOFF   = 4;
    localparam int APT_WINDOW   = 16;
    localparam int APT_CUTOFF   = 12;
    localparam int STARTUP_BITS = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic              clear;
    logic              bit_in;
    logic              bit_valid;
    logic              word_ready;
    logic [WORD_W-1:0] word_out;
    logic              word_valid;
    logic              rct_fail;
    logic              apt_fail;
    logic              alarm;
    logic              overflow;
    logic              startup_done;
`ifdef TRNG_HEALTH_STATS_EN
    logic [15:0]       rct_fail_cnt;
    logic [15:0]       apt_fail_cnt;
    logic [31:0]       words_cnt;
`endif

    always #5 clk = ~clk;

    trng_health_packer #(
        .WORD_W      (WORD_W),
        .RCT_CUTOFF  (RCT_CUTOFF),
        .APT_WINDOW  (APT_WINDOW),
        .APT_CUTOFF  (APT_CUTOFF),
        .STARTUP_BITS(STARTUP_BITS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .clear       (clear),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .word_out    (word_out),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .rct_fail    (rct_fail),
        .apt_fail    (apt_fail),
        .alarm       (alarm),
        .overflow    (overflow),
        .startup_done(startup_done)
`ifdef TRNG_HEALTH_STATS_EN
        ,
        .rct_fail_cnt(rct_fail_cnt),
        .apt_fail_cnt(apt_fail_cnt),
        .words_cnt   (words_cnt)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    // Scoreboard and reference-model state
    logic [WORD_W-1:0] exp_q[$];
    bit                hist[$];
    bit                m_alarm, m_full, m_ovf, m_sd, exp_rct, exp_apt;
    int                m_rct_cnt, m_apt_cnt, m_words;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drop the unread word from the scoreboard unless it is taken this cycle.
    task automatic discard_pending(input bit xfer);
        if (m_full && !xfer && exp_q.size() > 0) void'(exp_q.pop_back());
        m_full = 1'b0;
    endtask

    task automatic model_step(input bit b, input bit v, input bit rdy, input bit en, input bit clr);
        bit                xfer;
        int                n, run, ws, cnt;
        logic [WORD_W-1:0] w;
        exp_rct = 1'b0;
        exp_apt = 1'b0;
        xfer    = m_full && rdy;
        if (xfer) m_words++;
        if (clr) begin
            discard_pending(xfer);
            hist.delete();
            m_alarm = 1'b0; m_ovf = 1'b0; m_sd = 1'b0;
            return;
        end
        if (v && en && !m_alarm) begin
            hist.push_back(b);
            n   = hist.size();
            run = 0;
            for (int i = n - 1; i >= 0; i--) begin
                if (hist[i] != b) break;
                run++;
            end
            ws  = ((n - 1) / APT_WINDOW) * APT_WINDOW;
            cnt = 0;
            for (int i = ws; i < n; i++) if (hist[i] == hist[ws]) cnt++;
            exp_rct = (run == RCT_CUTOFF);
            exp_apt = (cnt == APT_CUTOFF);
            if (exp_rct) m_rct_cnt++;
            if (exp_apt) m_apt_cnt++;
            if (exp_rct || exp_apt) begin
                m_alarm = 1'b1;
                discard_pending(xfer);
                return;
            end
            if (n == STARTUP_BITS) m_sd = 1'b1;
            if (n > STARTUP_BITS && ((n - STARTUP_BITS) % WORD_W) == 0) begin
                w = '0;
                for (int i = n - WORD_W; i < n; i++) w = {w[WORD_W-2:0], hist[i]};
                if (!m_full || rdy) begin
                    exp_q.push_back(w);
                    m_full = 1'b1;
                    return;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        if (xfer) m_full = 1'b0;
    endtask

    task automatic check_status();
        chk("word_valid",   32'(word_valid),   32'(m_full));
        chk("rct_fail",     32'(rct_fail),     32'(exp_rct));
        chk("apt_fail",     32'(apt_fail),     32'(exp_apt));
        chk("alarm",        32'(alarm),        32'(m_alarm));
        chk("overflow",     32'(overflow),     32'(m_ovf));
        chk("startup_done", 32'(startup_done), 32'(m_sd));
`ifdef TRNG_HEALTH_STATS_EN
        chk("rct_fail_cnt", 32'(rct_fail_cnt), 32'(m_rct_cnt));
        chk("apt_fail_cnt", 32'(apt_fail_cnt), 32'(m_apt_cnt));
        chk("words_cnt",    words_cnt,         32'(m_words));
`endif
    endtask

    // One clock: drive at negedge, check registered status after the posedge.
    task automatic step(input bit b, input bit v, input bit rdy, input bit en, input bit clr);
        @(negedge clk);
        bit_in = b; bit_valid = v; word_ready = rdy; enable = en; clear = clr;
        model_step(b, v, rdy, en, clr);
        @(posedge clk);
        #1;
        check_status();
    endtask

    task automatic send_byte(input logic [7:0] val, input bit rdy);
        logic [7:0] t;
        t = val;
        for (int i = 7; i >= 0; i--) step(t[i], 1'b1, rdy, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; bit_valid = 1'b0; clear = 1'b0; word_ready = 1'b0;
        if (m_full && exp_q.size() > 0) void'(exp_q.pop_back());
        hist.delete();
        m_alarm = 1'b0; m_full = 1'b0; m_ovf = 1'b0; m_sd = 1'b0;
        exp_rct = 1'b0; exp_apt = 1'b0;
        m_rct_cnt = 0; m_apt_cnt = 0; m_words = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_status();
        chk("rst_word_out", 32'(word_out), 32'h0);
    endtask

    // Monitor: compare word_out against the scoreboard on every handshake.
    always @(negedge clk) begin
        #1;
        if (!rst && word_valid && word_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL word_unexpected: got %0h expected none", word_out);
            end else begin
                chk("word_out", 32'(word_out), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit last_b;
        bit b, v, rdy, en, clr;
        int flip_mod;
        rst = 1'b1; enable = 1'b1; clear = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; word_ready = 1'b1;
        do_reset();

        // 1: startup on alternating bits, then 1010_0110 -> 8'hA6, one-cycle valid
        for (int i = 0; i < 8; i++) step(((i % 2) == 0), 1'b1, 1'b1, 1'b1, 1'b0);
        chk("t1_startup_done", 32'(startup_done), 32'h1);
        send_byte(8'hA6, 1'b1);
        chk("t1_word", 32'(word_out), 32'hA6);
        chk("t1_valid", 32'(word_valid), 32'h1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("t1_valid_drop", 32'(word_valid), 32'h0);

        // 2: four ones in RUN -> RCT failure and alarm; later bits ignored
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("t2_rct_fail", 32'(rct_fail), 32'h1);
        chk("t2_alarm", 32'(alarm), 32'h1);
        send_byte(8'h5A, 1'b1);
        chk("t2_no_word", 32'(word_valid), 32'h0);

        // clear with bit_valid high: bit dropped, alarm released
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("clr_alarm", 32'(alarm), 32'h0);

        // 3: 0001 0001 0001 000 -> APT failure on the 12th zero
        for (int i = 0; i < 15; i++) step((i % 4) == 3, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("t3_apt_fail", 32'(apt_fail), 32'h1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

        // 4: ready low, two words -> first held, second dropped, overflow set
        for (int i = 0; i < 8; i++) step(((i % 2) == 0), 1'b1, 1'b0, 1'b1, 1'b0);
        send_byte(8'h5A, 1'b0);
        send_byte(8'h96, 1'b0);
        chk("t4_overflow", 32'(overflow), 32'h1);
        chk("t4_held", 32'(word_out), 32'h5A);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("t4_valid_drop", 32'(word_valid), 32'h0);

        // 5: word completes in the same cycle as the handshake
        send_byte(8'hA5, 1'b0);
        for (int i = 7; i >= 1; i--) step(((8'h69 >> i) & 1) != 0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("t5_valid", 32'(word_valid), 32'h1);
        chk("t5_word", 32'(word_out), 32'h69);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        // 6: alarm, then clear with bit_valid high; stats survive clear
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("t6_alarm", 32'(alarm), 32'h0);
        chk("t6_startup", 32'(startup_done), 32'h0);
        do_reset();

        // randomized phase with varying bias, enable gaps, clears and a reset
        last_b = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            flip_mod = 2 + (k / 500) % 3;
            b   = last_b ^ ($urandom_range(0, flip_mod - 1) != 0);
            last_b = b;
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            en  = ($urandom_range(0, 15) != 0);
            clr = m_alarm ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 299) == 0);
            step(b, v, rdy, en, clr);
            if (k == 1700) do_reset();
        end
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
